// File: rtl/fetch_unit.sv
// fetch_unit: two-word instruction fetch stage of the OrgaSmall core.
// Reads hi at pc, lo at pc+1, hands the pair to the decoder, advances pc by 2.
module fetch_unit #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] inst_hi,
    output logic [WORD_SIZE-1:0] inst_lo,
    output logic [ADDR_BITS-1:0] inst_addr,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    input  logic                 pc_load,
    input  logic [ADDR_BITS-1:0] pc_target,
    input  logic                 halt,
    output logic [ADDR_BITS-1:0] pc
);

    typedef enum logic [1:0] {
        REQ_HI = 2'd0,
        REQ_LO = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [ADDR_BITS-1:0] PC_ONE = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] PC_TWO = ADDR_BITS'(2);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] hi_q, hi_d;
    logic [WORD_SIZE-1:0] lo_q, lo_d;
    logic                 valid_q, valid_d;

    // State and instruction registers; reset clears everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ_HI;
            pc_q    <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and memory request; a redirect overrides any capture.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        valid_d  = valid_q;
        mem_rd   = 1'b0;
        mem_addr = pc_q;

        unique case (state_q)
            REQ_HI: begin
                if (!halt) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        hi_d    = mem_rdata;
                        state_d = REQ_LO;
                    end
                end
            end
            REQ_LO: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q + PC_ONE;
                if (mem_ready) begin
                    lo_d    = mem_rdata;
                    addr_d  = pc_q;
                    pc_d    = pc_q + PC_TWO;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    valid_d = 1'b0;
                    state_d = REQ_HI;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = REQ_HI;
            end
        endcase

        if (pc_load) begin
            pc_d    = pc_target;
            addr_d  = addr_q;
            hi_d    = hi_q;
            lo_d    = lo_q;
            valid_d = 1'b0;
            state_d = REQ_HI;
        end
    end

    assign inst_hi    = hi_q;
    assign inst_lo    = lo_q;
    assign inst_addr  = addr_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with an instruction scoreboard
// and a wait-state memory responder.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [7:0] inst_hi;
    logic [7:0] inst_lo;
    logic [7:0] inst_addr;
    logic       inst_valid;
    logic       inst_ready;
    logic       pc_load;
    logic [7:0] pc_target;
    logic       halt;
    logic [7:0] pc;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   wait_n = 0;
    int   wcnt = 0;
    bit   seen = 0;

    fetch_unit #(.WORD_SIZE(8), .ADDR_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .inst_hi(inst_hi), .inst_lo(inst_lo),
        .inst_addr(inst_addr), .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .pc_load(pc_load), .pc_target(pc_target),
        .halt(halt), .pc(pc)
    );

    always #5 clk = ~clk;

    // Memory contents: mem[a] = a ^ 0xA5.
    assign mem_rdata = mem_addr ^ 8'hA5;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a);
        exp_t e;
        e.hi   = a ^ 8'hA5;
        e.lo   = (a + 8'd1) ^ 8'hA5;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Memory responder: wait_n idle cycles, then one ready cycle.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mem_rd) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end else if (wcnt >= wait_n) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end
    end

    // Scoreboard: each new valid instruction is checked against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (inst_valid === 1'b1 && !seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_unexpected observed=%0h expected=none",
                           inst_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_hi", inst_hi, e.hi);
                    chk("sb_lo", inst_lo, e.lo);
                    chk("sb_addr", inst_addr, e.addr);
                end
            end
            if (inst_valid !== 1'b1) seen = 0;
        end
    end

    initial begin
        rst        = 1'b1;
        halt       = 1'b0;
        pc_load    = 1'b0;
        pc_target  = 8'h00;
        inst_ready = 1'b1;
        wait_n     = 0;
        step();

        // Zero-wait fetch, back to back.
        do_reset();
        chk("rst_pc", pc, 8'h00);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_hi", inst_hi, 8'h00);
        chk("rst_lo", inst_lo, 8'h00);
        chk("rst_iaddr", inst_addr, 8'h00);
        chk("rst_maddr", mem_addr, 8'h00);
        chk("rst_mrd", mem_rd, 1'b1);
        push(8'h00);
        push(8'h02);
        step();
        chk("t1_e1_valid", inst_valid, 1'b0);
        chk("t1_e1_maddr", mem_addr, 8'h01);
        step();
        chk("t1_e2_valid", inst_valid, 1'b1);
        chk("t1_e2_hi", inst_hi, 8'hA5);
        chk("t1_e2_lo", inst_lo, 8'hA4);
        chk("t1_e2_pc", pc, 8'h02);
        step();
        chk("t1_e3_valid", inst_valid, 1'b0);
        step();
        step();
        inst_ready = 1'b0;
        chk("t1_e5_valid", inst_valid, 1'b1);
        chk("t1_e5_iaddr", inst_addr, 8'h02);
        chk("t1_e5_pc", pc, 8'h04);

        // Two wait states per read, then consumer stalls.
        wait_n = 2;
        do_reset();
        push(8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("t2_hi_maddr", mem_addr, 8'h00);
            chk("t2_hi_mrd", mem_rd, 1'b1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t2_lo_maddr", mem_addr, 8'h01);
            chk("t2_lo_mrd", mem_rd, 1'b1);
            chk("t2_lo_valid", inst_valid, 1'b0);
            step();
        end
        chk("t2_e6_valid", inst_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_valid", inst_valid, 1'b1);
            chk("t3_hi", inst_hi, 8'hA5);
            chk("t3_lo", inst_lo, 8'hA4);
            chk("t3_mrd", mem_rd, 1'b0);
            chk("t3_pc", pc, 8'h02);
        end
        wait_n = 0;
        inst_ready = 1'b1;
        push(8'h02);
        step();
        inst_ready = 1'b0;
        chk("t3_resume_valid", inst_valid, 1'b0);
        chk("t3_resume_mrd", mem_rd, 1'b1);
        chk("t3_resume_maddr", mem_addr, 8'h02);
        step();
        step();
        chk("t3_next_valid", inst_valid, 1'b1);
        chk("t3_next_iaddr", inst_addr, 8'h02);

        // Redirect while the low word is completing.
        inst_ready = 1'b1;
        do_reset();
        step();
        pc_load   = 1'b1;
        pc_target = 8'h40;
        push(8'h40);
        step();
        pc_load    = 1'b0;
        inst_ready = 1'b0;
        chk("t4_pc", pc, 8'h40);
        chk("t4_maddr", mem_addr, 8'h40);
        chk("t4_mrd", mem_rd, 1'b1);
        chk("t4_valid", inst_valid, 1'b0);
        chk("t4_hi_kept", inst_hi, 8'hA5);
        chk("t4_lo_kept", inst_lo, 8'h00);
        step();
        step();
        chk("t4_next_valid", inst_valid, 1'b1);
        chk("t4_next_iaddr", inst_addr, 8'h40);
        chk("t4_next_hi", inst_hi, 8'hE5);
        chk("t4_next_lo", inst_lo, 8'hE4);

        // Redirect from HOLD to the top address, wrap to 0.
        pc_load   = 1'b1;
        pc_target = 8'hFF;
        push(8'hFF);
        step();
        pc_load = 1'b0;
        chk("t5_valid", inst_valid, 1'b0);
        chk("t5_maddr_hi", mem_addr, 8'hFF);
        step();
        chk("t5_maddr_lo", mem_addr, 8'h00);
        step();
        chk("t5_valid2", inst_valid, 1'b1);
        chk("t5_iaddr", inst_addr, 8'hFF);
        chk("t5_hi", inst_hi, 8'h5A);
        chk("t5_lo", inst_lo, 8'hA5);
        chk("t5_pc", pc, 8'h01);

        // Halt during HOLD, accept, stay idle, then resume.
        halt       = 1'b1;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t6_acc_valid", inst_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_halt_mrd", mem_rd, 1'b0);
            chk("t6_halt_pc", pc, 8'h01);
            step();
        end
        halt = 1'b0;
        #1;
        chk("t6_resume_mrd", mem_rd, 1'b1);
        chk("t6_resume_maddr", mem_addr, 8'h01);
        step();
        chk("t6_lo_maddr", mem_addr, 8'h02);

        // Reset while the low word is outstanding.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_pc", pc, 8'h00);
        chk("t6_rst_valid", inst_valid, 1'b0);
        chk("t6_rst_hi", inst_hi, 8'h00);
        chk("t6_rst_lo", inst_lo, 8'h00);

        inst_ready = 1'b0;
        halt       = 1'b1;
        step();
        step();
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the OrgaSmall core; sits directly upstream of the decoder.
- Each instruction is two memory words. It reads the high word at pc and the low word at pc+1 over a byte-wide memory read port.
- Presents inst_hi/inst_lo with a valid/ready handshake, then advances pc by 2.
- Supports pc redirect (jumps) and a halt request.

Parameters:
- WORD_SIZE, 8, memory/instruction word width (matches `WORD_SIZE).
- ADDR_BITS, 8, program address width; pc wraps modulo 2^ADDR_BITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_addr  output  ADDR_BITS  read address.
- mem_rd  output  1  read request.
- mem_rdata  input  WORD_SIZE  read data; valid when mem_ready=1.
- mem_ready  input  1  read completion; meaningful only while mem_rd=1.
- inst_hi  output  WORD_SIZE  word fetched from inst_addr.
- inst_lo  output  WORD_SIZE  word fetched from inst_addr+1.
- inst_addr  output  ADDR_BITS  address of inst_hi.
- inst_valid  output  1  inst_* hold a complete instruction.
- inst_ready  input  1  consumer accepts the instruction.
- pc_load  input  1  redirect request.
- pc_target  input  ADDR_BITS  redirect address (odd values allowed).
- halt  input  1  level; suppresses new fetches.
- pc  output  ADDR_BITS  current pc register.

Behaviour:
- Reset, applied at the next edge from any state: state=REQ_HI, pc=0, inst_hi=inst_lo=0, inst_addr=0, inst_valid=0. Consequently mem_rd=0 only if halt=1, and mem_addr=0.
- mem_rd and mem_addr are combinational from state and pc. inst_* are registered.
- REQ_HI:
  - halt=1: mem_rd=0; stay in REQ_HI.
  - Otherwise: mem_rd=1, mem_addr=pc. On an edge with mem_ready=1: inst_hi<=mem_rdata, go to REQ_LO.
- REQ_LO:
  - mem_rd=1, mem_addr=pc+1 (wraps). halt is ignored here.
  - On mem_ready=1: inst_lo<=mem_rdata, inst_addr<=pc, pc<=pc+2 (wraps), inst_valid<=1, go to HOLD.
- HOLD:
  - mem_rd=0. inst_valid=1, and inst_* are held stable.
  - On inst_ready=1: inst_valid<=0, go to REQ_HI.
- Request stability: while mem_rd=1 and mem_ready=0, mem_addr and mem_rd must not change (wait states, unlimited length).
- mem_ready while mem_rd=0 is ignored.
- Minimum throughput: 3 cycles per instruction with zero-wait memory and inst_ready=1.
- pc_load=1 at an edge (priority below rst, above everything else):
  - pc<=pc_target, inst_valid<=0, state<=REQ_HI.
  - A mem_ready/mem_rdata in the same cycle is discarded, and inst_hi/inst_lo are not updated.
  - If in HOLD with inst_ready=1, the handshake is treated as completed; the result is identical.
  - Allowed while halt=1.
- Wrap: pc=2^ADDR_BITS-1 fetches hi from the top address and lo from 0; pc becomes 1.
- Reset mid-operation: in-flight data is discarded, with no partial update of inst_*.

Test Plan:
- 1. Zero-wait memory, mem[a]=a^0xA5, inst_ready=1, rst released at edge 0.
  - inst_valid=1 after edge 2: inst_hi=0xA5, inst_lo=0xA4, inst_addr=0x00, pc=0x02.
  - Next instruction valid after edge 5 with inst_addr=0x02.
- 2. mem_ready delayed 2 cycles per read.
  - mem_addr 0x00 held 3 cycles, then 0x01 held 3 cycles, with mem_rd=1 throughout.
  - inst_valid rises after edge 6.
- 3. inst_ready=0 for 5 cycles after first valid.
  - inst_valid=1, inst_hi=0xA5, inst_lo=0xA4 stable; mem_rd=0; pc=0x02 throughout.
  - Fetch resumes one edge after inst_ready=1.
- 4. pc_load=1, pc_target=0x40, asserted in REQ_LO with mem_ready=1.
  - Next cycle: mem_addr=0x40, mem_rd=1, inst_valid=0.
  - Next valid has inst_addr=0x40, inst_hi=0xE5, inst_lo=0xE4.
- 5. pc_load with pc_target=0xFF.
  - mem_addr 0xFF then 0x00; inst_addr=0xFF, inst_hi=0x5A, inst_lo=0xA5, pc=0x01.
- 6. Halt and reset.
  - halt=1 during HOLD, then accept: mem_rd stays 0 and pc is stable for 4 cycles; halt=0 resumes with mem_addr=pc.
  - rst=1 in REQ_LO: after the next edge, pc=0, inst_valid=0, inst_hi=inst_lo=0.
